// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: default bus geometry, the descriptor
// length width and the reader state encoding.
package dma_pkg;
    localparam int DMA_DATA_WIDTH = 32;
    localparam int DMA_ADDR_WIDTH = 9;
    localparam int DMA_LEN_WIDTH  = DMA_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } dma_state_t;
endpackage

// File: rtl/dma_rd_fifo.sv
// Output buffer for the DMA reader: synchronous FIFO holding a data word plus
// its end-of-descriptor flag, with a registered occupancy count.
module dma_rd_fifo
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_last,
    output logic [CNT_W-1:0]      count,
    output logic                  empty
);
    logic [DATA_WIDTH:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign {pop_last, pop_data} = store[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/dma_reader.sv
// DMA read engine: walks a descriptor through the SRAM read port and streams
// the words, in address order, to the PE array through a small output FIFO.
module dma_reader
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  mem_ceb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_a,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] port_out,
    output logic                  port_valid,
    input  logic                  port_ready,
    output logic                  port_last,
    output logic                  busy,
    output logic                  done
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      rem_q;
    logic                  issue_p0;
    logic                  vld_p1;
    logic                  last_p1;
    logic                  zero_done_q;
    logic                  accept;
    logic                  pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last;
    logic [CNT_W-1:0]      occupancy;

    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = !fifo_empty && port_ready;
    // Reserve a FIFO slot for every read in flight; built from registers only.
    assign occupancy = fifo_count + CNT_W'(vld_p1);

    always_comb begin
        state_d  = state_q;
        issue_p0 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_len != '0)) state_d = ST_READ;
            end
            ST_READ: begin
                issue_p0 = (occupancy < CNT_W'(FIFO_DEPTH));
                if (issue_p0 && (rem_q == LEN_W'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && fifo_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // p0 -> p1: SRAM read issued, data returns on mem_q next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_p1      <= issue_p0;
            last_p1     <= issue_p0 && (rem_q == LEN_W'(1));
            zero_done_q <= accept && (cmd_len == '0);
            if (accept && (cmd_len != '0)) begin
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
            end else if (issue_p0) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end
        end
    end

    // p1 -> p2: returned word captured into the output FIFO
    dma_rd_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (vld_p1),
        .push_data(mem_q),
        .push_last(last_p1),
        .pop      (pop),
        .pop_data (fifo_data),
        .pop_last (fifo_last),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign mem_ceb    = !issue_p0;
    assign mem_web    = 1'b1;
    assign mem_a      = addr_q;
    assign port_valid = !fifo_empty;
    assign port_out   = fifo_empty ? '0 : fifo_data;
    assign port_last  = !fifo_empty && fifo_last;
    assign busy       = (state_q != ST_IDLE);
    assign done       = zero_done_q || ((state_q == ST_DRAIN) && pop && fifo_last);
endmodule

// File: tb/tb_dma_reader.sv
// Randomized bench for dma_reader: a behavioural SRAM plus queues of expected
// read addresses and delivered words derived from each descriptor.
module tb_dma_reader;
    localparam int DW        = 32;
    localparam int AW        = 9;
    localparam int LW        = AW + 1;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          mem_ceb;
    logic          mem_web;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] port_out;
    logic          port_valid;
    logic          port_ready;
    logic          port_last;
    logic          busy;
    logic          done;

    dma_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_ceb(mem_ceb), .mem_web(mem_web),
        .mem_a(mem_a), .mem_q(mem_q), .port_out(port_out), .port_valid(port_valid),
        .port_ready(port_ready), .port_last(port_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [MEM_WORDS];
    always @(posedge clk) begin
        if (!mem_ceb) mem_q <= sram[mem_a];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];

    int   cyc = 0, done_cnt = 0, done_cyc = 0, rise_cyc = 0;
    int   xfers = 0, issues = 0, vld_cycles = 0, out_cnt = 0;
    bit   mon_en = 1'b0;
    logic prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_out = '0;
    logic [DW:0]   exp_w;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (port_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = port_valid;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", port_valid, 1);
                check("hold_data", port_out, prev_out);
                check("hold_last", port_last, prev_last);
            end
            if (port_valid) vld_cycles++;
            if (!mem_ceb) begin
                issues++;
                out_cnt++;
                if (addr_q.size() == 0) check("extra_issue", 1, 0);
                else check("rd_addr", mem_a, addr_q.pop_front());
            end
            if (port_valid && port_ready) begin
                xfers++;
                out_cnt--;
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else begin
                    exp_w = exp_q.pop_front();
                    check("word", port_out, exp_w[DW-1:0]);
                    check("last", port_last, exp_w[DW]);
                end
            end
            if (!mem_ceb) check("outstanding_le_depth", out_cnt <= DEPTH, 1);
            if (done && port_valid) check("done_with_last", port_last && port_ready, 1);
            prev_stall = port_valid && !port_ready;
            prev_out   = port_out;
            prev_last  = port_last;
        end else begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end
    end

    // 0: always ready, 1: toggle, 2: random, other: held low
    int rdy_mode = 0;
    initial begin
        port_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       port_ready = 1'b1;
                1:       port_ready = ~port_ready;
                2:       port_ready = 1'($urandom_range(0, 1));
                default: port_ready = 1'b0;
            endcase
        end
    end

    task automatic check_rst(input string tag);
        check({tag, "_cmd_ready"},  cmd_ready, 0);
        check({tag, "_mem_ceb"},    mem_ceb, 1);
        check({tag, "_mem_web"},    mem_web, 1);
        check({tag, "_mem_a"},      mem_a, 0);
        check({tag, "_port_valid"}, port_valid, 0);
        check({tag, "_port_last"},  port_last, 0);
        check({tag, "_port_out"},   port_out, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
    endtask

    task automatic load_model(input logic [AW-1:0] a, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), sram[(int'(a) + i) % MEM_WORDS]});
            addr_q.push_back(AW'(int'(a) + i));
        end
    endtask

    // hs is the handshake cycle; the descriptor is latched at the edge that
    // ends it, so the first word appears two cycles after that edge (hs+3).
    task automatic run_cmd(input logic [AW-1:0] a, input int len, input int mode, input int hold);
        int hs, d0, is0, vc0;
        rdy_mode = (hold > 0) ? 3 : mode;
        repeat (2) @(posedge clk);
        #1;
        load_model(a, len);
        d0  = done_cnt;
        is0 = issues;
        vc0 = vld_cycles;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_addr  = a;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        hs = cyc + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #2;
            check("stalled_issues", issues - is0, DEPTH);
            rdy_mode = mode;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (3) @(posedge clk);
        #2;
        check("done_once", done_cnt - d0, 1);
        check("words_left", exp_q.size(), 0);
        check("issues_left", addr_q.size(), 0);
        check("busy_after", busy, 0);
        if (len == 0) begin
            check("len0_no_issue", issues - is0, 0);
            check("len0_no_valid", vld_cycles - vc0, 0);
            check("len0_done_lat", done_cyc - hs, 1);
        end else if (mode == 0 && hold == 0) begin
            check("first_word_lat", rise_cyc - hs, 3);
            check("done_lat", done_cyc - hs, len + 2);
            check("valid_cycles", vld_cycles - vc0, len);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, x0;
        logic [AW-1:0] ra;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        foreach (sram[i]) sram[i] = $urandom;
        repeat (3) @(posedge clk);
        #2;
        check_rst("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("cmd_ready_after_rst", cmd_ready, 1);
        mon_en = 1'b1;

        run_cmd(9'h010, 8, 0, 0);
        run_cmd(9'h1FE, 4, 0, 0);
        run_cmd(AW'($urandom), 16, 1, 0);
        run_cmd(AW'($urandom), 0, 0, 0);
        run_cmd(AW'($urandom), 512, 0, 20);
        for (int k = 0; k < 6; k++) begin
            run_cmd(AW'($urandom), $urandom_range(1, 40), 2, 0);
        end

        // abandon a len=10 descriptor while its fifth word is on the port
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        ra = AW'($urandom);
        load_model(ra, 10);
        d0 = done_cnt;
        x0 = xfers;
        cmd_addr  = ra;
        cmd_len   = LW'(10);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && (xfers - x0) < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("words_before_rst", xfers - x0, 4);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        check_rst("mid_rst");
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("no_done_on_abort", done_cnt - d0, 0);
        check("busy_after_abort", busy, 0);
        run_cmd(AW'($urandom), 10, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
